// File: rtl/price_fifo.sv
// price_fifo: first-word fall-through buffer between the market-data parser
// and the SMA block. It can drop a sample that repeats the previous accepted
// price, and it counts samples lost because the buffer was full.
module price_fifo #(
  parameter  int DATA_WIDTH = 18,
  parameter  int DEPTH      = 16,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  dedup_en,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_ready,
  output logic [AW:0]           count,
  output logic [15:0]           ovf_cnt
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_count;
  logic [15:0]           r_ovf_cnt;
  logic [DATA_WIDTH-1:0] r_last_data;
  logic                  r_last_vld;

  logic w_full;
  logic w_empty;
  logic w_accept;
  logic w_dup;
  logic w_store;
  logic w_pop;
  logic w_drop;

  // Handshake decode; full/empty come only from the registered count, so no
  // input reaches an output combinationally. A pop never frees room for a
  // write in the same cycle.
  always_comb begin
    w_full   = (r_count == (AW+1)'(DEPTH));
    w_empty  = (r_count == '0);
    w_accept = wr_valid & ~w_full;
    w_dup    = dedup_en & r_last_vld & (wr_data == r_last_data);
    w_store  = w_accept & ~w_dup;
    w_pop    = rd_ready & ~w_empty;
    w_drop   = wr_valid & w_full;
  end

  // Storage array: written on every store, never reset.
  always_ff @(posedge clk) begin
    if (w_store) r_mem[r_wr_ptr] <= wr_data;
  end

  // Pointers, occupancy count and overflow counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_ovf_cnt <= '0;
    end else begin
      if (w_store) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_store && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_store && w_pop) r_count <= r_count - 1'b1;
      if (w_drop && r_ovf_cnt != '1) r_ovf_cnt <= r_ovf_cnt + 1'b1;
    end
  end

  // Last accepted sample, loaded whether it was stored or discarded as a
  // duplicate; samples dropped on full never reach it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_data <= '0;
      r_last_vld  <= 1'b0;
    end else if (w_accept) begin
      r_last_data <= wr_data;
      r_last_vld  <= 1'b1;
    end
  end

  // Output decode; head sample is forced to zero while empty.
  always_comb begin
    wr_ready = ~w_full;
    rd_valid = ~w_empty;
    rd_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    count    = r_count;
    ovf_cnt  = r_ovf_cnt;
  end

endmodule

// File: tb/tb_price_fifo.sv
// Testbench for price_fifo: constant vector table, directed corner cases and
// a randomized run against a queue-based reference model.
module tb_price_fifo;

  localparam int DW = 18;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          dedup_en;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_ready;
  logic [4:0]    count;
  logic [15:0]   ovf_cnt;

  price_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .dedup_en(dedup_en),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .count(count), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int m_q[$];
  int m_last;
  bit m_last_vld;
  int m_ovf;

  typedef struct {
    logic wv; int wd; logic dd; logic rr;
    int ecnt; logic erv; int erd; logic ewr; int eovf;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t v(logic wv, int wd, logic dd, logic rr,
                             int ecnt, logic erv, int erd, logic ewr, int eovf);
    vec_t r;
    r.wv = wv; r.wd = wd; r.dd = dd; r.rr = rr;
    r.ecnt = ecnt; r.erv = erv; r.erd = erd; r.ewr = ewr; r.eovf = eovf;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_last_vld = 0;
    m_last = 0;
    m_ovf = 0;
  endtask

  // Applies one cycle of stimulus to the model using the pre-edge state.
  task automatic model_step(input bit wv, input int wd, input bit dd, input bit rr);
    int pre = m_q.size();
    if (wv) begin
      if (pre == DEPTH) begin
        if (m_ovf < 65535) m_ovf++;
      end else begin
        if (!(dd && m_last_vld && wd == m_last)) m_q.push_back(wd);
        m_last = wd;
        m_last_vld = 1;
      end
    end
    if (rr && pre > 0) void'(m_q.pop_front());
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".count"}, int'(count), m_q.size());
    chk({tag, ".rd_valid"}, int'(rd_valid), int'(m_q.size() > 0));
    chk({tag, ".rd_data"}, int'(rd_data), (m_q.size() > 0) ? m_q[0] : 0);
    chk({tag, ".wr_ready"}, int'(wr_ready), int'(m_q.size() < DEPTH));
    chk({tag, ".ovf_cnt"}, int'(ovf_cnt), m_ovf);
  endtask

  // One clock cycle: drive, advance the model, sample 1 time unit after the edge.
  task automatic cyc(input bit wv, input int wd, input bit dd, input bit rr,
                     input string tag);
    wr_valid = wv; wr_data = DW'(wd); dedup_en = dd; rd_ready = rr;
    model_step(wv, wd, dd, rr);
    @(posedge clk);
    #1;
    chk_model(tag);
  endtask

  task automatic do_reset();
    wr_valid = 0; wr_data = '0; dedup_en = 0; rd_ready = 0;
    rst_n = 0;
    model_reset();
    @(posedge clk); @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0; wr_valid = 0; wr_data = '0; dedup_en = 0; rd_ready = 0;

    // ordered write/read, then dedup on and off
    tbl[0]  = v(1, 100, 0, 0, 1, 1, 100, 1, 0);
    tbl[1]  = v(1, 101, 0, 0, 2, 1, 100, 1, 0);
    tbl[2]  = v(1, 102, 0, 0, 3, 1, 100, 1, 0);
    tbl[3]  = v(0, 0,   0, 1, 2, 1, 101, 1, 0);
    tbl[4]  = v(0, 0,   0, 1, 1, 1, 102, 1, 0);
    tbl[5]  = v(0, 0,   0, 1, 0, 0, 0,   1, 0);
    tbl[6]  = v(1, 500, 1, 0, 1, 1, 500, 1, 0);
    tbl[7]  = v(1, 500, 1, 0, 1, 1, 500, 1, 0);
    tbl[8]  = v(1, 501, 1, 0, 2, 1, 500, 1, 0);
    tbl[9]  = v(1, 500, 1, 0, 3, 1, 500, 1, 0);
    tbl[10] = v(0, 0,   0, 1, 2, 1, 501, 1, 0);
    tbl[11] = v(0, 0,   0, 1, 1, 1, 500, 1, 0);
    tbl[12] = v(0, 0,   0, 1, 0, 0, 0,   1, 0);
    tbl[13] = v(1, 500, 0, 0, 1, 1, 500, 1, 0);
    tbl[14] = v(1, 500, 0, 0, 2, 1, 500, 1, 0);
    tbl[15] = v(1, 501, 0, 0, 3, 1, 500, 1, 0);
    tbl[16] = v(1, 500, 0, 0, 4, 1, 500, 1, 0);
    tbl[17] = v(0, 0,   0, 1, 3, 1, 500, 1, 0);
    tbl[18] = v(0, 0,   0, 1, 2, 1, 501, 1, 0);
    tbl[19] = v(0, 0,   0, 1, 1, 1, 500, 1, 0);
    tbl[20] = v(0, 0,   0, 1, 0, 0, 0,   1, 0);

    do_reset();
    chk("reset.count", int'(count), 0);
    chk("reset.rd_valid", int'(rd_valid), 0);
    chk("reset.rd_data", int'(rd_data), 0);
    chk("reset.wr_ready", int'(wr_ready), 1);
    chk("reset.ovf_cnt", int'(ovf_cnt), 0);

    for (int i = 0; i < 21; i++) begin
      wr_valid = tbl[i].wv; wr_data = DW'(tbl[i].wd);
      dedup_en = tbl[i].dd; rd_ready = tbl[i].rr;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d.count", i), int'(count), tbl[i].ecnt);
      chk($sformatf("tbl%0d.rd_valid", i), int'(rd_valid), int'(tbl[i].erv));
      chk($sformatf("tbl%0d.rd_data", i), int'(rd_data), tbl[i].erd);
      chk($sformatf("tbl%0d.wr_ready", i), int'(wr_ready), int'(tbl[i].ewr));
      chk($sformatf("tbl%0d.ovf_cnt", i), int'(ovf_cnt), tbl[i].eovf);
    end

    // streaming across pointer wrap with the reader always ready
    do_reset();
    for (int i = 0; i < 40; i++) begin
      cyc(1, 2000 + i, 0, 1, "stream");
      chk("stream.count_le1", int'(count <= 1), 1);
    end
    cyc(0, 0, 0, 1, "stream_drain");
    chk("stream.ovf_zero", int'(ovf_cnt), 0);

    // fill to full, overflow, pop frees room only on the next cycle
    for (int i = 0; i < DEPTH; i++) cyc(1, 3000 + i, 0, 0, "fill");
    chk("full.count", int'(count), 16);
    chk("full.wr_ready", int'(wr_ready), 0);
    for (int i = 0; i < 3; i++) cyc(1, 3100 + i, 0, 0, "ovf");
    chk("ovf.ovf_cnt", int'(ovf_cnt), 3);
    chk("ovf.count", int'(count), 16);
    cyc(0, 0, 0, 1, "pop1");
    chk("pop1.wr_ready", int'(wr_ready), 1);
    cyc(1, 3200, 0, 0, "refill");
    chk("refill.count", int'(count), 16);
    cyc(1, 3300, 0, 1, "full_rw");
    chk("full_rw.count", int'(count), 15);
    chk("full_rw.ovf_cnt", int'(ovf_cnt), 4);
    chk("full_rw.rd_data", int'(rd_data), 3002);

    // asynchronous reset mid-stream
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 4000 + i, 1, 0, "pre_rst");
    #3;
    rst_n = 0;
    #1;
    chk("async_rst.count", int'(count), 0);
    chk("async_rst.rd_valid", int'(rd_valid), 0);
    chk("async_rst.rd_data", int'(rd_data), 0);
    chk("async_rst.wr_ready", int'(wr_ready), 1);
    chk("async_rst.ovf_cnt", int'(ovf_cnt), 0);
    model_reset();
    wr_valid = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    cyc(1, 4004, 1, 0, "post_rst");
    chk("post_rst.count", int'(count), 1);
    chk("post_rst.rd_data", int'(rd_data), 4004);

    // randomized run: write-heavy, then read-heavy, then mixed
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bit wv, rr, dd;
      int wd;
      if (i < 200) begin
        wv = ($urandom_range(0, 9) < 8); rr = ($urandom_range(0, 9) < 3);
      end else if (i < 400) begin
        wv = ($urandom_range(0, 9) < 3); rr = ($urandom_range(0, 9) < 8);
      end else begin
        wv = $urandom_range(0, 1) == 1; rr = $urandom_range(0, 1) == 1;
      end
      dd = $urandom_range(0, 1) == 1;
      wd = 1000 + $urandom_range(0, 3);
      cyc(wv, wd, dd, rr, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute time guard so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/price_fifo.md
# price_fifo

Buffers 18-bit price samples from the market-data parser and delivers them to the SMA block, one sample per accepted handshake. It is the producer side of the SMA's input interface: it decouples the bursty parser from the averaging logic, optionally suppresses repeated prices so the SMA sees only price changes, and counts samples lost to overflow.

## Interface

- DATA_WIDTH, 18: price sample width.
- DEPTH, 16: number of storage entries; power of two, at least 2.
- AW, log2(DEPTH): pointer width. Derived, not overridden.

- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_valid  in  1  parser presents a sample.
- wr_data  in  DATA_WIDTH  price sample.
- wr_ready  out  1  FIFO can take a sample; equals not-full.
- dedup_en  in  1  when 1, a sample equal to the last accepted sample is discarded.
- rd_valid  out  1  head sample available to SMA; equals not-empty.
- rd_data  out  DATA_WIDTH  head sample (first-word fall-through); 0 when empty.
- rd_ready  in  1  SMA consumes head sample.
- count  out  AW+1  entries currently stored, 0..DEPTH.
- ovf_cnt  out  16  samples lost to a full FIFO; saturates at 0xFFFF.

## Operation

- Write handshake: a sample is accepted when wr_valid and wr_ready are both 1 at a rising edge.
- Accepted sample handling:
  - If dedup_en=1, last_vld=1 and wr_data equals last_data, the sample is discarded. It is not stored and count does not change.
  - Otherwise the sample is stored at wr_ptr, and wr_ptr increments modulo DEPTH.
- last_data/last_vld: internal register. Loaded with every accepted sample, whether stored or discarded; last_vld is then set. Reset clears last_vld, so the first sample after reset is never discarded.
- dedup_en is sampled each cycle. Changing it never affects samples already stored.
- Read handshake: the head sample pops when rd_valid and rd_ready are both 1. rd_ptr increments modulo DEPTH.
  - rd_ready with rd_valid=0 has no effect.
- Count rules:
  - count = number stored.
  - Increments on a store without a pop, decrements on a pop without a store, and is unchanged when both occur.
- Full: count==DEPTH, so wr_ready=0.
  - wr_valid while full increments ovf_cnt, saturating at 0xFFFF, and the sample is dropped.
  - A pop in the same cycle does not make room for that write: wr_ready depends only on the current count.
  - Dropped samples do not update last_data.
- Empty: count==0, so rd_valid=0 and rd_data=0.
- Pointer wrap: pointers wrap from DEPTH-1 to 0. Full and empty are distinguished by count, not by pointer equality.
- Reset mid-operation: all stored contents are logically lost and the FIFO returns to empty immediately. The storage array itself need not be cleared.

## Timing

- Reset values: wr_ready=1, rd_valid=0, rd_data=0, count=0, ovf_cnt=0, pointers 0, last_vld=0.
- Write-to-read latency: 1 cycle. A sample stored at edge N appears on rd_data with rd_valid=1 after edge N; the SMA may pop it at edge N+1.
- rd_data is combinational from storage at rd_ptr and changes only after an edge.
- wr_ready and rd_valid are decoded from the registered count. There is no combinational path from wr_valid or rd_ready to any output.
- Sustained throughput: 1 sample per cycle with simultaneous store and pop at any fill level 1..DEPTH-1.
- Dedup comparison uses last_data as it stood before the current edge, so back-to-back equal samples are both checked correctly.

## Test plan

- Reset, then write 100, 101, 102 on consecutive cycles with rd_ready=0 -> count=3, rd_valid=1, rd_data=100. Then hold rd_ready=1 for 3 cycles -> rd_data 100, 101, 102 in order, then rd_valid=0, rd_data=0, count=0.
- dedup_en=1, write 500, 500, 501, 500 -> stored 500, 501, 500 and count=3. Repeat with dedup_en=0 -> count=4.
- Fill 16 entries with rd_ready=0, then hold wr_valid for 3 more cycles -> wr_ready=0, ovf_cnt=3, count=16. Pop one -> wr_ready=1 next cycle and the next write is stored.
- Full FIFO with wr_valid=1 and rd_ready=1 in the same cycle -> a pop occurs, the write is dropped, ovf_cnt increments, and count=15.
- Stream 40 sequential samples with rd_ready=1 constantly -> output order is exact across pointer wrap, count never exceeds 1, and ovf_cnt=0.
- Store 5 samples, assert rst_n=0 for one cycle mid-stream -> outputs return to their reset values immediately. The first sample after reset equals the pre-reset last_data and is stored even with dedup_en=1.
